// File: rtl/fifo_rr_drain.sv
// ---------------------------------------------------------------------------
// fifo_rr_drain
// Drains four per-class source FIFOs into one downstream FIFO. Each cycle at
// most one non-empty source is picked in round-robin order and its read strobe
// is pulsed. One cycle later the source's output word is captured and written
// downstream. The downstream full/almost_full flags are honoured so that no
// word is dropped or duplicated.
//
// Ports:
//   clk              clock
//   reset            synchronous, active-high reset
//   enable           1 = new pops allowed; an in-flight push always completes
//   src_empty        per-source empty flag
//   src_almost_empty per-source almost-empty flag (one word or fewer left)
//   src_data         per-source output word, source i at [i*BITNUMBER +: BITNUMBER]
//   dst_full         downstream full flag
//   dst_almost_full  downstream almost-full flag
//   src_rd           one-hot read strobe to the sources
//   dst_wr           write strobe to the downstream FIFO
//   dst_data         word written downstream
//   grant_idx        index of the most recent pop
//   busy             a pop or a push is in flight
//   pop_count        words moved downstream, wraps at 255
// ---------------------------------------------------------------------------
module fifo_rr_drain #(
   parameter int BITNUMBER = 8,
   parameter int NSRC      = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NSRC-1:0]           src_empty,
   input  logic [NSRC-1:0]           src_almost_empty,
   input  logic [NSRC*BITNUMBER-1:0] src_data,
   input  logic                      dst_full,
   input  logic                      dst_almost_full,
   output logic [NSRC-1:0]           src_rd,
   output logic                      dst_wr,
   output logic [BITNUMBER-1:0]      dst_data,
   output logic [1:0]                grant_idx,
   output logic                      busy,
   output logic [7:0]                pop_count
);

   // Round-robin search starting one past the last grant. The result is
   // {found, index}; the loop visits last+1 .. last+4 modulo 4.
   function automatic logic [2:0] rr_pick(input logic [NSRC-1:0] elig,
                                          input logic [1:0]      last);
      logic       found;
      logic [1:0] idx;
      logic [1:0] cand;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 1; k <= NSRC; k++) begin
         cand = last + 2'(k);
         if (!found && elig[cand]) begin
            found = 1'b1;
            idx   = cand;
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   logic [NSRC-1:0] elig_s;
   logic            gate_s;
   logic [2:0]      pick_s;
   logic            pop_s;
   logic [1:0]      win_idx_s;
   logic [NSRC-1:0] win_onehot_s;

   logic [1:0]      last_r;
   logic            pop_pend_r;
   logic [1:0]      pend_idx_r;

   // Eligibility and winner selection. A source showing almost_empty while
   // being strobed this cycle is excluded: its flags have not yet caught up
   // with the read, so popping it again could underflow it.
   always_comb begin
      elig_s = '0;
      for (int i = 0; i < NSRC; i++) begin
         elig_s[i] = !src_empty[i] && !(src_almost_empty[i] && src_rd[i]);
      end
      // almost_full closes the gate so the word already in flight still fits.
      gate_s       = enable && !dst_full && !dst_almost_full;
      pick_s       = rr_pick(elig_s, last_r);
      pop_s        = gate_s && pick_s[2];
      win_idx_s    = pick_s[1:0];
      win_onehot_s = {{(NSRC-1){1'b0}}, 1'b1} << win_idx_s;
   end

   // Pop stage: strobe the winner and remember which source owes us a word.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_rd     <= '0;
         grant_idx  <= 2'd0;
         last_r     <= 2'd3;
         pop_pend_r <= 1'b0;
         pend_idx_r <= 2'd0;
      end else if (pop_s) begin
         src_rd     <= win_onehot_s;
         grant_idx  <= win_idx_s;
         last_r     <= win_idx_s;
         pop_pend_r <= 1'b1;
         pend_idx_r <= win_idx_s;
      end else begin
         src_rd     <= '0;
         pop_pend_r <= 1'b0;
      end
   end

   // Push stage: the strobed source presents its word now; forward it.
   always_ff @(posedge clk) begin
      if (reset) begin
         dst_wr    <= 1'b0;
         dst_data  <= '0;
         pop_count <= 8'd0;
      end else if (pop_pend_r) begin
         dst_wr    <= 1'b1;
         dst_data  <= src_data[pend_idx_r*BITNUMBER +: BITNUMBER];
         pop_count <= pop_count + 8'd1;
      end else begin
         dst_wr    <= 1'b0;
      end
   end

   // busy mirrors the registered strobes: pop issued or push issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
      end else begin
         busy <= pop_s || pop_pend_r;
      end
   end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_drain
// Self-checking bench for fifo_rr_drain. Four behavioural source FIFOs
// (show-ahead data, flags updated at the edge that consumes a read) feed the
// DUT. Each scenario pushes the expected grant indices and data words to
// scoreboard queues; a negedge monitor pops and compares them whenever the
// DUT strobes a source or writes downstream.
// ---------------------------------------------------------------------------
module tb_fifo_rr_drain;

   localparam int BW = 8;
   localparam int NS = 4;

   logic             clk;
   logic             reset;
   logic             enable;
   logic [NS-1:0]    src_empty;
   logic [NS-1:0]    src_almost_empty;
   logic [NS*BW-1:0] src_data;
   logic             dst_full;
   logic             dst_almost_full;
   logic [NS-1:0]    src_rd;
   logic             dst_wr;
   logic [BW-1:0]    dst_data;
   logic [1:0]       grant_idx;
   logic             busy;
   logic [7:0]       pop_count;

   int checks = 0;
   int errors = 0;
   int rd_err = 0;

   logic [7:0] mem [NS][512];
   int         wptr [NS];
   int         rptr [NS];

   int         exp_idx  [$];
   logic [7:0] exp_data [$];

   fifo_rr_drain #(.BITNUMBER(BW), .NSRC(NS)) dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .src_empty        (src_empty),
      .src_almost_empty (src_almost_empty),
      .src_data         (src_data),
      .dst_full         (dst_full),
      .dst_almost_full  (dst_almost_full),
      .src_rd           (src_rd),
      .dst_wr           (dst_wr),
      .dst_data         (dst_data),
      .grant_idx        (grant_idx),
      .busy             (busy),
      .pop_count        (pop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Source FIFO model: data is the head word; flags come from the occupancy.
   always @* begin
      for (int i = 0; i < NS; i++) begin
         src_empty[i]              = (wptr[i] - rptr[i]) == 0;
         src_almost_empty[i]       = (wptr[i] - rptr[i]) <= 1;
         src_data[i*BW +: BW]      = mem[i][rptr[i] & 511];
      end
   end

   // Source FIFO model: consume a word on each strobe, count underflows.
   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         if (src_rd[i]) begin
            if (wptr[i] == rptr[i]) rd_err <= rd_err + 1;
            else                    rptr[i] <= rptr[i] + 1;
         end
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!reset) begin
         if (src_rd != 4'b0000) begin
            if (exp_idx.size() == 0) begin
               check("unexpected_pop", 32'(exp_idx.size()), 32'd1);
            end else begin
               int e;
               e = exp_idx.pop_front();
               check("pop_onehot", 32'(src_rd), 32'(4'b0001 << e));
               check("grant_idx", 32'(grant_idx), 32'(e));
            end
         end
         if (dst_wr) begin
            check("wr_into_full", 32'(dst_full), 32'd0);
            if (exp_data.size() == 0) begin
               check("unexpected_wr", 32'(exp_data.size()), 32'd1);
            end else begin
               logic [7:0] d;
               d = exp_data.pop_front();
               check("dst_data", 32'(dst_data), 32'(d));
            end
         end
      end
   end

   task automatic push_src(input int s, input logic [7:0] w);
      mem[s][wptr[s] & 511] = w;
      wptr[s] = wptr[s] + 1;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_data.size() != 0 || exp_idx.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", 32'(n < budget), 32'd1);
   endtask

   initial begin
      int n_rd;
      int n_wr;
      int n;
      for (int i = 0; i < NS; i++) begin
         wptr[i] = 0;
         rptr[i] = 0;
      end
      reset = 1'b1;
      enable = 1'b1;
      dst_full = 1'b0;
      dst_almost_full = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values.
      check("rst_src_rd", 32'(src_rd), 32'd0);
      check("rst_dst_wr", 32'(dst_wr), 32'd0);
      check("rst_dst_data", 32'(dst_data), 32'd0);
      check("rst_grant", 32'(grant_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(pop_count), 32'd0);
      #1 reset = 1'b0;

      // All sources empty: nothing moves for 10 cycles.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("idle_rd", 32'(src_rd), 32'd0);
         check("idle_wr", 32'(dst_wr), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end
      check("idle_grant", 32'(grant_idx), 32'd0);

      // Two words per source: strict rotation, back-to-back.
      for (int w = 0; w < 2; w++) begin
         for (int s = 0; s < NS; s++) begin
            exp_idx.push_back(s);
            exp_data.push_back(8'((8'hA0 + 8'(s) * 8'h10) + 8'(w)));
         end
      end
      for (int s = 0; s < NS; s++) begin
         push_src(s, 8'(8'hA0 + 8'(s) * 8'h10));
         push_src(s, 8'(8'hA1 + 8'(s) * 8'h10));
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("rr_back_to_back", 32'(src_rd != 4'b0000), 32'd1);
      end
      wait_drain(20);
      check("rr_count", 32'(pop_count), 32'd8);

      // Last word of source 2: exactly one strobe and one write.
      exp_idx.push_back(2);
      exp_data.push_back(8'h5C);
      push_src(2, 8'h5C);
      n_rd = 0;
      n_wr = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (src_rd[2]) n_rd++;
         if (dst_wr) n_wr++;
      end
      check("last_word_rd", 32'(n_rd), 32'd1);
      check("last_word_wr", 32'(n_wr), 32'd1);
      check("last_word_rd_err", 32'(rd_err), 32'd0);
      check("last_word_count", 32'(pop_count), 32'd9);

      // almost_full rises right after a pop: push completes, pops stall.
      for (int w = 0; w < 3; w++) begin
         exp_idx.push_back(0);
         exp_data.push_back(8'(8'h10 + 8'(w)));
         exp_idx.push_back(1);
         exp_data.push_back(8'(8'h20 + 8'(w)));
         push_src(0, 8'(8'h10 + 8'(w)));
         push_src(1, 8'(8'h20 + 8'(w)));
      end
      @(negedge clk);
      check("af_first_pop", 32'(src_rd), 32'd1);
      dst_almost_full = 1'b1;
      @(negedge clk);
      check("af_no_pop", 32'(src_rd), 32'd0);
      check("af_inflight_wr", 32'(dst_wr), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("af_hold", 32'(src_rd), 32'd0);
         check("af_hold_wr", 32'(dst_wr), 32'd0);
      end
      dst_almost_full = 1'b0;
      @(negedge clk);
      check("af_resume", 32'(src_rd != 4'b0000), 32'd1);
      wait_drain(30);
      check("af_count", 32'(pop_count), 32'd15);

      // Reset while a pop from source 1 is in flight: no write follows.
      exp_idx.push_back(1);
      push_src(1, 8'h77);
      n = 0;
      while (!src_rd[1] && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("abort_pop_seen", 32'(src_rd[1]), 32'd1);
      #1 reset = 1'b1;
      @(negedge clk);
      check("abort_src_rd", 32'(src_rd), 32'd0);
      check("abort_dst_wr", 32'(dst_wr), 32'd0);
      check("abort_dst_data", 32'(dst_data), 32'd0);
      check("abort_grant", 32'(grant_idx), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_count", 32'(pop_count), 32'd0);
      exp_idx.delete();
      #1 reset = 1'b0;
      exp_idx.push_back(0);
      exp_data.push_back(8'h66);
      exp_idx.push_back(1);
      exp_data.push_back(8'h67);
      push_src(0, 8'h66);
      push_src(1, 8'h67);
      @(negedge clk);
      check("post_reset_grant0", 32'(src_rd), 32'd1);
      wait_drain(20);
      check("post_reset_count", 32'(pop_count), 32'd2);

      // 260 words from source 3 only: pop_count wraps to 4.
      #1 reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 260; k++) begin
         exp_idx.push_back(3);
         exp_data.push_back(8'((k * 7 + 3) & 255));
         push_src(3, 8'((k * 7 + 3) & 255));
      end
      wait_drain(800);
      check("stream_count_wrap", 32'(pop_count), 32'd4);
      check("final_rd_err", 32'(rd_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
